div_strobe_gen: RTL and testbench
=================================

Name: div_strobe_gen

Overview:
Multi-channel programmable strobe generator, successor to the fixed divide-by-4 flag generator. Each channel has its own wrap counter, with a runtime-programmable divide ratio and phase. Each channel emits a one-cycle `po_flag` strobe once per period. Sits beside the clock source and supplies enable strobes to downstream blocks on the same clock; no derived clocks.

Parameters:
- NUM_CH, 2, number of independent strobe channels (1..16).
- CNT_W, 8, width of the per-channel counter, divide ratio and phase.
- DEF_DIV, 4, divide ratio loaded at reset (2 <= DEF_DIV <= 2^CNT_W-1).
- DEF_PHASE, 2, phase loaded at reset (DEF_PHASE < DEF_DIV).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ch_en  input  NUM_CH  per-channel run enable.
- sync_clr  input  1  realign all channels: counters to 0.
- cfg_vld  input  1  configuration request valid.
- cfg_rdy  output  1  configuration slot free.
- cfg_ch  input  max(1,clog2(NUM_CH))  target channel.
- cfg_div  input  CNT_W  new divide ratio (period in clk cycles).
- cfg_phase  input  CNT_W  new phase; counter value that triggers the strobe.
- cfg_err  output  1  one-cycle pulse: rejected configuration.
- po_flag  output  NUM_CH  per-channel one-cycle strobe.

Behaviour:
- Reset: asynchronous and active-high. It sets all registers immediately:
  - cnt[*]=0, div_cur[*]=DEF_DIV, phase_cur[*]=DEF_PHASE
  - po_flag=0, cfg_err=0, pend_vld=0, cfg_rdy=1
- Per-channel counter, registered, with priority top to bottom:
  - ch_en[c]=0: cnt[c] holds 0.
  - sync_clr=1: cnt[c] is cleared to 0.
  - cnt[c]==div_cur[c]-1: cnt[c] wraps to 0.
  - Otherwise: cnt[c] increments by 1.
- Strobe: po_flag[c] <= ch_en[c] & ~sync_clr & (cnt[c]==phase_cur[c]). This is registered, so it is high the cycle after the counter equals phase. Period is div_cur cycles; width is exactly 1 cycle. With the defaults, po_flag rises on the 4th cycle after enable, then every 4 cycles (identical to the legacy block).
- Config handshake:
  - cfg_rdy = ~pend_vld, taken from a register.
  - A transfer is accepted when cfg_vld & cfg_rdy.
  - cfg_* are sampled at acceptance only.
- Config legality, checked at acceptance. A transfer is illegal if any of these hold:
  - cfg_div < 2
  - cfg_phase >= cfg_div
  - cfg_ch >= NUM_CH
- Illegal transfer: cfg_err=1 for the following cycle only, pend_vld is unchanged (remains 0), and the channel state is untouched.
- Legal transfer: pend_vld <= 1 next cycle, and ch/div/phase are latched into the shadow slot. cfg_rdy drops the cycle after acceptance.
- Applying a pending config to target channel t, at the first of these events seen with pend_vld=1:
  - (a) ch_en[t]=0: applied on that edge.
  - (b) sync_clr=1: applied on that edge.
  - (c) cnt[t]==div_cur[t]-1, i.e. the wrap: applied on that edge.
- On apply, div_cur[t] and phase_cur[t] update and pend_vld clears. cfg_rdy returns high the next cycle. The new period starts at cnt=0, so there is no truncated or double strobe.
- No other channel is affected by a config.
- A strobe decided on the wrap edge uses the old phase_cur, which is the value before the update.
- Simultaneous events:
  - sync_clr together with a wrap: the clear wins; the result is identical (cnt=0).
  - sync_clr together with a phase match: the strobe is suppressed.
  - ch_en falling while a strobe is due: the strobe is suppressed.
- A new request cannot be accepted in the same cycle as an apply, because cfg_rdy is still low then.
- Reset mid-operation: a pending config is discarded, and outputs clear within the reset assertion with no clock required.
- Arithmetic: counters are unsigned CNT_W bits. div_cur-1 is computed without underflow, since div_cur >= 2 is guaranteed.

Test Plan:
- Reset, then ch_en=2'b11 from cycle 0 → po_flag[0] and [1] high on cycles 3, 7, 11, … Each pulse is 1 cycle wide; cfg_rdy=1; cfg_err=0.
- Accept {ch=1, div=6, phase=0} at cnt[1]=1 → cfg_rdy low from the next cycle. Apply at the cnt[1]=3 wrap. Subsequent po_flag[1] pulses are 6 cycles apart, each 1 cycle after cnt[1]=0. po_flag[0] is unchanged.
- Illegal requests → cfg_err pulses once per request, cfg_rdy stays 1, and the period is unchanged:
  - div=1
  - div=5, phase=5
  - ch=2 with NUM_CH=2
- ch_en[0]=0, accept {ch=0, div=3, phase=1}, then raise ch_en[0] → the config is applied while disabled. First strobe 2 cycles after enable, then every 3 cycles.
- Run both channels, pulse sync_clr at an arbitrary cycle → both counters are 0 on the next cycle and no strobe is issued during the sync_clr cycle. A pending config is applied at that edge.
- Assert rst asynchronously mid-period with a config pending → po_flag, cfg_err and pend_vld are 0 immediately and cfg_rdy=1. After release, the defaults (div 4, phase 2) resume.

Source files
------------

// File: rtl/div_strobe_gen.sv
// Multi-channel programmable strobe generator: per-channel wrap counters with
// runtime divide ratio and phase, updated through a single-slot config handshake.
//
// Config slot FSM
//   state  | meaning
//   S_IDLE | slot empty, cfg_rdy high, accepting requests
//   S_PEND | legal config latched, waiting for its channel to wrap/clear/disable
module div_strobe_gen #(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 8,
  parameter int DEF_DIV   = 4,
  parameter int DEF_PHASE = 2,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_clr,
  input  logic              cfg_vld,
  output logic              cfg_rdy,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] po_flag
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } slot_state_t;

  slot_state_t state_q, state_d;

  logic              rdy_q;
  logic              err_q, err_d;
  logic              take;
  logic              pend_vld;
  logic [CH_W-1:0]   pend_ch;
  logic [CNT_W-1:0]  pend_div;
  logic [CNT_W-1:0]  pend_phase;
  logic [NUM_CH-1:0] apply_vec;
  logic              apply_any;

  logic              div_small;
  logic              phase_big;
  logic              ch_oob;
  logic              cfg_legal;

  assign div_small = (cfg_div < CNT_W'(2));
  assign phase_big = (cfg_phase >= cfg_div);
  // Extra bit so an index equal to NUM_CH is representable when NUM_CH is a power of two
  assign ch_oob    = ({1'b0, cfg_ch} >= (CH_W+1)'(NUM_CH));
  assign cfg_legal = ~div_small & ~phase_big & ~ch_oob;

  assign pend_vld  = (state_q == S_PEND);
  assign apply_any = |apply_vec;

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    take    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cfg_vld && rdy_q) begin
          if (cfg_legal) begin
            state_d = S_PEND;
            take    = 1'b1;
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      S_PEND: begin
        if (apply_any) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      rdy_q   <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == S_IDLE);
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_ch    <= '0;
      pend_div   <= CNT_W'(DEF_DIV);
      pend_phase <= CNT_W'(DEF_PHASE);
    end else if (take) begin
      pend_ch    <= cfg_ch;
      pend_div   <= cfg_div;
      pend_phase <= cfg_phase;
    end
  end

  assign cfg_rdy = rdy_q;
  assign cfg_err = err_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] phase_q;
    logic             flag_q;
    logic             at_wrap;
    logic             is_tgt;

    // div_q never drops below 2, so the subtraction cannot underflow
    assign at_wrap      = (cnt_q == div_q - CNT_W'(1));
    assign is_tgt       = (pend_ch == CH_W'(c));
    assign apply_vec[c] = pend_vld & is_tgt & (~ch_en[c] | sync_clr | at_wrap);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q   <= '0;
        div_q   <= CNT_W'(DEF_DIV);
        phase_q <= CNT_W'(DEF_PHASE);
        flag_q  <= 1'b0;
      end else begin
        // Strobe decision uses the phase in force before any apply on this edge
        flag_q <= ch_en[c] & ~sync_clr & (cnt_q == phase_q);

        if (!ch_en[c]) begin
          cnt_q <= '0;
        end else if (sync_clr) begin
          cnt_q <= '0;
        end else if (at_wrap) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end

        if (apply_vec[c]) begin
          div_q   <= pend_div;
          phase_q <= pend_phase;
        end
      end
    end

    assign po_flag[c] = flag_q;
  end

endmodule

// File: tb/tb_div_strobe_gen.sv
// Directed bench for div_strobe_gen; three channels so that an out-of-range
// channel index (3) is encodable on cfg_ch. Channel 2 stays disabled throughout.
module tb_div_strobe_gen;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ch_en;
  logic              sync_clr;
  logic              cfg_vld;
  logic              cfg_rdy;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic [CNT_W-1:0]  cfg_phase;
  logic              cfg_err;
  logic [NUM_CH-1:0] po_flag;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  div_strobe_gen #(
    .NUM_CH   (NUM_CH),
    .CNT_W    (CNT_W),
    .DEF_DIV  (4),
    .DEF_PHASE(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ch_en    (ch_en),
    .sync_clr (sync_clr),
    .cfg_vld  (cfg_vld),
    .cfg_rdy  (cfg_rdy),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_phase(cfg_phase),
    .cfg_err  (cfg_err),
    .po_flag  (po_flag)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive_cfg(input logic [CH_W-1:0] ch, input logic [CNT_W-1:0] d,
                           input logic [CNT_W-1:0] p);
    cfg_vld   = 1'b1;
    cfg_ch    = ch;
    cfg_div   = d;
    cfg_phase = p;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    logic e0, e1;
    rst       = 1'b1;
    ch_en     = '0;
    sync_clr  = 1'b0;
    cfg_vld   = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    cfg_phase = '0;

    #2;
    check("rst_flag", po_flag, 3'b000);
    check("rst_rdy", cfg_rdy, 1'b1);
    check("rst_err", cfg_err, 1'b0);

    @(posedge clk);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    ch_en = 3'b011;
    cyc   = 0;

    // Defaults: both channels strobe in cycles 3, 7, 11
    for (int j = 1; j <= 13; j++) begin
      step();
      check("A_flag", po_flag, (j % 4 == 3) ? 3'b011 : 3'b000);
    end
    check("A_rdy", cfg_rdy, 1'b1);
    check("A_err", cfg_err, 1'b0);

    // cnt[1]=1 in cycle 13: request div 6 / phase 0 on channel 1
    drive_cfg(2'd1, 8'd6, 8'd0);
    step();
    cfg_vld = 1'b0;
    check("B_rdy_low", cfg_rdy, 1'b0);
    check("B_flag", po_flag, 3'b000);
    for (int j = 15; j <= 30; j++) begin
      step();
      e0 = (j % 4 == 3);
      e1 = (j == 15) || (j >= 17 && (j - 17) % 6 == 0);
      check("B_flag", po_flag, {1'b0, e1, e0});
      if (j == 15) check("B_rdy_pend", cfg_rdy, 1'b0);
      if (j == 16) check("B_rdy_back", cfg_rdy, 1'b1);
    end

    // Illegal requests, one per two cycles
    drive_cfg(2'd0, 8'd1, 8'd0);
    step();
    cfg_vld = 1'b0;
    check("C_err_div1", cfg_err, 1'b1);
    check("C_rdy_div1", cfg_rdy, 1'b1);
    check("C_flag", po_flag, {1'b0, 1'b0, 1'b1});
    step();
    check("C_err_clr1", cfg_err, 1'b0);
    drive_cfg(2'd0, 8'd5, 8'd5);
    step();
    cfg_vld = 1'b0;
    check("C_err_phase", cfg_err, 1'b1);
    check("C_rdy_phase", cfg_rdy, 1'b1);
    step();
    check("C_err_clr2", cfg_err, 1'b0);
    drive_cfg(2'd3, 8'd5, 8'd1);
    step();
    cfg_vld = 1'b0;
    check("C_err_ch", cfg_err, 1'b1);
    check("C_rdy_ch", cfg_rdy, 1'b1);
    check("C_flag", po_flag, 3'b011);
    step();
    check("C_err_clr3", cfg_err, 1'b0);
    for (int j = 37; j <= 41; j++) begin
      step();
      e0 = (j % 4 == 3);
      e1 = ((j - 17) % 6 == 0);
      check("C_flag", po_flag, {1'b0, e1, e0});
    end

    // Config channel 0 while disabled, then enable it
    ch_en = 3'b010;
    step();
    check("D_flag_off", po_flag, 3'b000);
    drive_cfg(2'd0, 8'd3, 8'd1);
    step();
    cfg_vld = 1'b0;
    check("D_rdy_low", cfg_rdy, 1'b0);
    check("D_flag", po_flag, 3'b000);
    step();
    check("D_rdy_back", cfg_rdy, 1'b1);
    check("D_flag", po_flag, 3'b000);
    ch_en = 3'b011;
    for (int j = 45; j <= 53; j++) begin
      step();
      e0 = (j >= 46) && ((j - 46) % 3 == 0);
      e1 = ((j - 17) % 6 == 0);
      check("D_flag", po_flag, {1'b0, e1, e0});
    end

    // Pending config on channel 1 applied by sync_clr; ch0 strobe due is suppressed
    drive_cfg(2'd1, 8'd5, 8'd4);
    step();
    cfg_vld = 1'b0;
    check("E_rdy_low", cfg_rdy, 1'b0);
    check("E_flag", po_flag, 3'b000);
    sync_clr = 1'b1;
    step();
    sync_clr = 1'b0;
    check("E_sync_suppress", po_flag, 3'b000);
    check("E_rdy_back", cfg_rdy, 1'b1);
    for (int j = 56; j <= 65; j++) begin
      step();
      e0 = (j >= 57) && ((j - 57) % 3 == 0);
      e1 = (j == 60) || (j == 65);
      check("E_flag", po_flag, {1'b0, e1, e0});
    end

    // Async reset mid-period with a config pending
    drive_cfg(2'd0, 8'd7, 8'd3);
    step();
    cfg_vld = 1'b0;
    check("F_rdy_low", cfg_rdy, 1'b0);
    check("F_flag_pre", po_flag, 3'b001);
    #2;
    rst = 1'b1;
    #1;
    check("F_async_flag", po_flag, 3'b000);
    check("F_async_err", cfg_err, 1'b0);
    check("F_async_rdy", cfg_rdy, 1'b1);
    step();
    check("F_hold_flag", po_flag, 3'b000);
    step();
    check("F_hold_rdy", cfg_rdy, 1'b1);
    rst = 1'b0;
    for (int r = 1; r <= 8; r++) begin
      step();
      check("F_def_flag", po_flag, (r % 4 == 3) ? 3'b011 : 3'b000);
    end
    check("F_rdy_end", cfg_rdy, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
